// File: rtl/axi_wr_arbiter_pkg.sv
// Shared AXI write constants and arbiter FSM state encodings.
package axi_wr_arbiter_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/axi_wr_arbiter_wmask_decode.sv
// Maps the core's one-hot size mask plus the low address bits to AWSIZE/WSTRB,
// flagging non-one-hot masks and misaligned addresses as illegal.
module wmask_decode
    import axi_wr_arbiter_pkg::*;
#(
    parameter int unsigned STRB_W = 8
) (
    input  logic [3:0]        wmask_i,
    input  logic [2:0]        addr_lo_i,
    output logic [2:0]        awsize_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              illegal_o
);

    logic [7:0] base;

    always_comb begin
        awsize_o  = AXI_SIZE_1B;
        base      = 8'h00;
        illegal_o = 1'b0;
        case (wmask_i)
            4'b1000: begin
                awsize_o  = AXI_SIZE_8B;
                base      = 8'hFF;
                illegal_o = (addr_lo_i != 3'd0);
            end
            4'b0100: begin
                awsize_o  = AXI_SIZE_4B;
                base      = 8'h0F;
                illegal_o = (addr_lo_i[1:0] != 2'd0);
            end
            4'b0010: begin
                awsize_o  = AXI_SIZE_2B;
                base      = 8'h03;
                illegal_o = addr_lo_i[0];
            end
            4'b0001: begin
                awsize_o  = AXI_SIZE_1B;
                base      = 8'h01;
            end
            default: illegal_o = 1'b1;
        endcase
        wstrb_o = STRB_W'(base) << addr_lo_i;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 single-beat write port between the LSU
// store path (req0) and the cache write-back path (req1); all outputs registered.
module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  req0_valid,
    input  logic [ADDR_W-1:0]     req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [3:0]            req0_wmask,
    output logic                  req0_done,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic [ADDR_W-1:0]     req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [3:0]            req1_wmask,
    output logic                  req1_done,
    output logic                  req1_err,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [2:0]        awsize_q, awsize_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              errp_q, errp_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_wmask;
    logic [2:0]        dec_size;
    logic [STRB_W-1:0] dec_strb;
    logic              dec_illegal;

    // Contention goes to the requester that did not win last; otherwise whoever is valid.
    assign sel       = (req0_valid && req1_valid) ? ~rr_q : req1_valid;
    assign sel_addr  = sel ? req1_addr : req0_addr;
    assign sel_wmask = sel ? req1_wmask : req0_wmask;

    wmask_decode #(
        .STRB_W (STRB_W)
    ) u_decode (
        .wmask_i   (sel_wmask),
        .addr_lo_i (sel_addr[2:0]),
        .awsize_o  (dec_size),
        .wstrb_o   (dec_strb),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awsize_d  = awsize_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        errp_d    = errp_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Skip the done-pulse cycle so the retiring requester can drop valid.
                if ((req0_valid || req1_valid) && !done0_q && !done1_q) begin
                    gnt_d    = sel;
                    addr_d   = sel_addr;
                    wdata_d  = sel ? req1_wdata : req0_wdata;
                    wstrb_d  = dec_strb;
                    awsize_d = dec_size;
                    errp_d   = dec_illegal;
                    if (dec_illegal) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                awvalid_d = awvalid_q && !AWREADY;
                wvalid_d  = wvalid_q && !WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (BVALID && bready_q) begin
                    state_d  = ST_DONE;
                    bready_d = 1'b0;
                    errp_d   = (BRESP != AXI_RESP_OKAY);
                end
            end
            default: begin
                done0_d = !gnt_q;
                done1_d = gnt_q;
                err0_d  = !gnt_q && errp_q;
                err1_d  = gnt_q && errp_q;
                rr_d    = gnt_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awsize_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            errp_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awsize_q  <= awsize_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            errp_q    <= errp_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign AWVALID   = awvalid_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = 8'd0;
    assign AWSIZE    = awsize_q;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WLAST     = wvalid_q;
    assign BREADY    = bready_q;
    assign req0_done = done0_q;
    assign req0_err  = err0_q;
    assign req1_done = done1_q;
    assign req1_err  = err1_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: latency, strobes, back-pressure, round-robin,
// illegal requests, error responses and reset during a response.
module tb_axi_wr_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic [3:0]  req0_wmask, req1_wmask;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  BRESP;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_wr_arbiter #(
        .ADDR_W (32),
        .DATA_W (64)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_wmask (req0_wmask),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_wmask (req1_wmask),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .AWADDR     (AWADDR),
        .AWLEN      (AWLEN),
        .AWSIZE     (AWSIZE),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .WLAST      (WLAST),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .BRESP      (BRESP)
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [63:0] d, input logic [3:0] m);
        req0_addr = a; req0_wdata = d; req0_wmask = m; req0_valid = 1'b1;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [63:0] d, input logic [3:0] m);
        req1_addr = a; req1_wdata = d; req1_wmask = m; req1_valid = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, AWVALID, 0);
        chk({tag, "_wvalid"},  WVALID, 0);
        chk({tag, "_bready"},  BREADY, 0);
        chk({tag, "_awaddr"},  AWADDR, 0);
        chk({tag, "_awsize"},  AWSIZE, 0);
        chk({tag, "_wstrb"},   WSTRB, 0);
        chk({tag, "_wdata"},   WDATA, 0);
        chk({tag, "_awlen"},   AWLEN, 0);
        chk({tag, "_done"},    {req0_done, req1_done, req0_err, req1_err}, 0);
    endtask

    initial begin
        int order[4];
        int n;
        int overlap;

        ARESET = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        step(); step();
        chk_idle_outputs("reset");
        ARESET = 1'b0;
        step();

        // 8B store, slaves always ready: AWVALID@1, BREADY@2, done@4
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        set_req0(32'h8000_0000, 64'h1122_3344_5566_7788, 4'b1000);
        step();
        chk("t1_awvalid", AWVALID, 1);
        chk("t1_wvalid",  WVALID, 1);
        chk("t1_wlast",   WLAST, 1);
        chk("t1_awaddr",  AWADDR, 32'h8000_0000);
        chk("t1_awsize",  AWSIZE, 3);
        chk("t1_wstrb",   WSTRB, 8'hFF);
        chk("t1_wdata",   WDATA, 64'h1122_3344_5566_7788);
        chk("t1_awlen",   AWLEN, 0);
        step();
        chk("t1_c2_valids", {AWVALID, WVALID}, 0);
        chk("t1_c2_bready", BREADY, 1);
        step();
        chk("t1_c3_bready", BREADY, 0);
        chk("t1_c3_done",   req0_done, 0);
        step();
        chk("t1_c4_done", {req0_done, req0_err, req1_done}, 3'b100);
        req0_valid = 1'b0;
        step();
        chk("t1_c5_done", req0_done, 0);

        // 1B store from req1, AWREADY late, WREADY immediate
        AWREADY = 1'b0; WREADY = 1'b1; BVALID = 1'b0;
        set_req1(32'h8000_0003, 64'h0000_0000_AB00_0000, 4'b0001);
        step();
        chk("t2_c1_valids", {AWVALID, WVALID}, 2'b11);
        chk("t2_wstrb",  WSTRB, 8'h08);
        chk("t2_awsize", AWSIZE, 0);
        chk("t2_awaddr", AWADDR, 32'h8000_0003);
        step();
        chk("t2_c2_valids", {AWVALID, WVALID}, 2'b10);
        step();
        chk("t2_c3_valids", {AWVALID, WVALID, BREADY}, 3'b100);
        chk("t2_c3_awaddr", AWADDR, 32'h8000_0003);
        AWREADY = 1'b1;
        step();
        chk("t2_c4", {AWVALID, WVALID, BREADY}, 3'b001);
        AWREADY = 1'b0;
        step();
        chk("t2_c5_bready", BREADY, 1);
        chk("t2_c5_done", req1_done, 0);
        BVALID = 1'b1;
        step();
        chk("t2_c6", {BREADY, req1_done}, 2'b00);
        BVALID = 1'b0;
        step();
        chk("t2_c7_done", {req1_done, req1_err, req0_done}, 3'b100);
        req1_valid = 1'b0;
        step();

        // Both held valid: expect grants 0,1,0,1 with no overlapping done pulses
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        set_req0(32'h8000_0100, 64'hAAAA_AAAA_AAAA_AAAA, 4'b1000);
        set_req1(32'h8000_0204, 64'hBBBB_BBBB_0000_0000, 4'b0100);
        n = 0;
        overlap = 0;
        for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
            step();
            if (req0_done && req1_done) overlap++;
            if (req0_done && n < 4) begin order[n] = 0; n++; end
            if (req1_done && n < 4) begin order[n] = 1; n++; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t3_count",   n, 4);
        chk("t3_overlap", overlap, 0);
        chk("t3_g0", order[0], 0);
        chk("t3_g1", order[1], 1);
        chk("t3_g2", order[2], 0);
        chk("t3_g3", order[3], 1);
        step(); step();

        // Misaligned 4B: no bus activity, error done two cycles later
        set_req0(32'h8000_0002, 64'h1, 4'b0100);
        step();
        chk("t4_c1", {AWVALID, WVALID, req0_done}, 0);
        step();
        chk("t4_c2_valids", {AWVALID, WVALID}, 0);
        chk("t4_c2_done", {req0_done, req0_err}, 2'b11);
        req0_valid = 1'b0;
        step();
        chk("t4_c3_done", req0_done, 0);

        // SLVERR on req1, then an OKAY store on req1
        BRESP = 2'b10;
        set_req1(32'h8000_0006, 64'h1234_0000_0000_0000, 4'b0010);
        step();
        chk("t5_wstrb",  WSTRB, 8'hC0);
        chk("t5_awsize", AWSIZE, 1);
        step(); step(); step();
        chk("t5_done", {req1_done, req1_err}, 2'b11);
        req1_valid = 1'b0;
        BRESP = 2'b00;
        step();
        set_req1(32'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 4'b1000);
        step();
        chk("t5b_awaddr", AWADDR, 32'h8000_0008);
        chk("t5b_wdata",  WDATA, 64'hDEAD_BEEF_CAFE_F00D);
        step(); step(); step();
        chk("t5b_done", {req1_done, req1_err}, 2'b10);
        req1_valid = 1'b0;
        step();

        // Reset while waiting for B; then contention must favour req1 (rr_ptr cleared)
        BVALID = 1'b0;
        set_req0(32'h8000_0010, 64'h5555, 4'b1000);
        step(); step();
        chk("t6_bready", BREADY, 1);
        ARESET = 1'b1;
        req0_valid = 1'b0;
        step();
        chk_idle_outputs("t6_rst");
        ARESET = 1'b0;
        step();
        BVALID = 1'b1;
        set_req0(32'h8000_0020, 64'h7777, 4'b1000);
        set_req1(32'h8000_0024, 64'h9999_0000_0000_0000, 4'b0100);
        step();
        chk("t6_awaddr", AWADDR, 32'h8000_0024);
        chk("t6_wstrb",  WSTRB, 8'hF0);
        step(); step(); step();
        chk("t6_done", {req1_done, req1_err, req0_done}, 3'b100);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
